// File: rtl/tpm_host_sequencer_pkg.sv
// tpm_defs: state encoding, command/response codes and startup types shared by the TPM host blocks
package tpm_defs;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_SETTLE, S_STARTUP, S_WAIT_SU, S_SELFTEST,
    S_WAIT_ST, S_READY, S_SHUTDOWN, S_WAIT_SD, S_FAIL
  } state_e;
  typedef enum logic [1:0] {
    CMD_STARTUP  = 2'd0,
    CMD_SHUTDOWN = 2'd1,
    CMD_SELFTEST = 2'd2
  } cmd_e;
  localparam logic [3:0] RC_FAILURE    = 4'b0000;
  localparam logic [3:0] RC_INITIALIZE = 4'b0001;
  localparam logic [3:0] RC_VALUE      = 4'b0010;
  localparam logic [3:0] RC_SUCCESS    = 4'b1111;
  localparam logic SU_CLEAR = 1'b0;
  localparam logic SU_STATE = 1'b1;
endpackage

// File: rtl/tpm_host_sequencer_if.sv
// tpm_host_sequencer_if: command/response handshake between the host sequencer and the TPM
interface tpm_host_sequencer_if import tpm_defs::*; ();
  logic       tpm_init;
  logic       cmd_valid;
  logic       cmd_ready;
  cmd_e       cmd_code;
  logic       cmd_param;
  logic       rsp_valid;
  logic [3:0] rsp_code;
  modport master (output tpm_init, cmd_valid, cmd_code, cmd_param, input cmd_ready, rsp_valid, rsp_code);
  modport slave  (input tpm_init, cmd_valid, cmd_code, cmd_param, output cmd_ready, rsp_valid, rsp_code);
endinterface

// File: rtl/tpm_host_sequencer_timeout_counter.sv
// tpm_timeout_counter: saturating cycle counter flagging the LIMIT-th counted cycle
module tpm_timeout_counter #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX  = W'(LIMIT);
  logic [W-1:0] r_count;
  // count enabled cycles, holding at MAX instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_en && r_count != MAX) r_count <= r_count + W'(1);
  assign o_expired = r_count >= LAST;
endmodule

// File: rtl/tpm_host_sequencer.sv
// tpm_host_sequencer: drives the TPM power-up (init, startup, self-test) and shutdown command sequence
module tpm_host_sequencer import tpm_defs::*; #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_startup_type,
  input  logic                        i_do_selftest,
  input  logic                        i_shutdown_req,
  input  logic                        i_shutdown_type,
  tpm_host_sequencer_if.master        bus,
  output logic                        o_ready,
  output logic                        o_busy,
  output logic                        o_fail,
  output logic [3:0]                  o_last_rc
);
  state_e     r_state, w_next;
  logic       r_param, r_retry, r_selftest;
  logic [3:0] r_last_rc;
  logic       w_settle_done, w_timeout, w_wait, w_ok, w_retry, w_go, w_cmd_valid;
  assign w_wait      = r_state inside {S_WAIT_SU, S_WAIT_ST, S_WAIT_SD};
  assign w_ok        = bus.rsp_code == RC_SUCCESS;
  assign w_retry     = bus.rsp_code == RC_VALUE && r_param == SU_STATE && !r_retry;
  assign w_go        = i_start && (r_state == S_IDLE || r_state == S_FAIL);
  assign w_cmd_valid = r_state inside {S_STARTUP, S_SELFTEST, S_SHUTDOWN};
  tpm_timeout_counter #(.LIMIT(SETTLE_CYCLES)) u_settle (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(r_state != S_SETTLE),
    .i_en(r_state == S_SETTLE), .o_expired(w_settle_done));
  tpm_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(!w_wait),
    .i_en(w_wait), .o_expired(w_timeout));
  // state register; reset abandons any sequence with nothing outstanding
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: a response in the last wait cycle takes priority over the timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (i_start) w_next = S_INIT;
      S_INIT:     w_next = S_SETTLE;
      S_SETTLE:   if (w_settle_done) w_next = S_STARTUP;
      S_STARTUP:  if (bus.cmd_ready) w_next = S_WAIT_SU;
      S_WAIT_SU:  if (bus.rsp_valid) w_next = w_ok ? (r_selftest ? S_SELFTEST : S_READY) : w_retry ? S_STARTUP : S_FAIL;
                  else if (w_timeout) w_next = S_FAIL;
      S_SELFTEST: if (bus.cmd_ready) w_next = S_WAIT_ST;
      S_WAIT_ST:  if (bus.rsp_valid) w_next = w_ok ? S_READY : S_FAIL;
                  else if (w_timeout) w_next = S_FAIL;
      S_READY:    if (i_shutdown_req) w_next = S_SHUTDOWN;
      S_SHUTDOWN: if (bus.cmd_ready) w_next = S_WAIT_SD;
      S_WAIT_SD:  if (bus.rsp_valid) w_next = w_ok ? S_IDLE : S_FAIL;
                  else if (w_timeout) w_next = S_FAIL;
      S_FAIL:     if (i_start) w_next = S_INIT;
      default:    w_next = S_IDLE;
    endcase
  end
  // command parameter, retry/self-test options sampled at start, and response capture
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_param    <= 1'b0;
      r_retry    <= 1'b0;
      r_selftest <= 1'b0;
      r_last_rc  <= RC_SUCCESS;
    end else begin
      if (w_go) begin
        r_param    <= i_startup_type;
        r_retry    <= 1'b0;
        r_selftest <= i_do_selftest;
      end else if (r_state == S_WAIT_SU && bus.rsp_valid && w_retry) begin
        r_param <= SU_CLEAR;
        r_retry <= 1'b1;
      end else if (r_state == S_WAIT_SU && w_next == S_SELFTEST) r_param <= 1'b0;
      else if (r_state == S_READY && i_shutdown_req) r_param <= i_shutdown_type;
      if (w_wait && bus.rsp_valid) r_last_rc <= bus.rsp_code;
      else if (w_wait && w_timeout) r_last_rc <= RC_FAILURE;
    end
  assign bus.tpm_init  = r_state == S_INIT;
  assign bus.cmd_valid = w_cmd_valid;
  assign bus.cmd_code  = r_state == S_SHUTDOWN ? CMD_SHUTDOWN : r_state == S_SELFTEST ? CMD_SELFTEST : CMD_STARTUP;
  assign bus.cmd_param = w_cmd_valid & r_param;
  assign o_ready       = r_state == S_READY;
  assign o_fail        = r_state == S_FAIL;
  assign o_busy        = !(r_state inside {S_IDLE, S_READY, S_FAIL});
  assign o_last_rc     = r_last_rc;
endmodule

// File: tb/tb_tpm_host_sequencer.sv
// tb_tpm_host_sequencer: randomized TPM responder checked against a transaction-level sequence model
module tb_tpm_host_sequencer;
  localparam int SETTLE = 4;
  localparam int TMO    = 200;
  localparam int P_IDLE = 0, P_SU = 1, P_ST = 2, P_READY = 3, P_SD = 4, P_FAIL = 5;
  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0, su_type = 1'b0, do_st = 1'b0, sd_req = 1'b0, sd_type = 1'b0;
  logic ready, busy, fail;
  logic [3:0] last_rc;
  int n_checks = 0, n_fail = 0;
  logic [3:0] m_rc = 4'hF;
  logic [4:0] plan[$];
  int g_hold = -1, g_delay = -1;
  tpm_host_sequencer_if bus();
  tpm_host_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_startup_type(su_type),
    .i_do_selftest(do_st), .i_shutdown_req(sd_req), .i_shutdown_type(sd_type),
    .bus(bus.master), .o_ready(ready), .o_busy(busy), .o_fail(fail), .o_last_rc(last_rc));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_init"}, bus.tpm_init, 0);
    check({tag, "_valid"}, bus.cmd_valid, 0);
    check({tag, "_code"}, bus.cmd_code, 0);
    check({tag, "_param"}, bus.cmd_param, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_rc"}, last_rc, 4'hF);
  endtask
  task automatic check_phase(input string tag, input int p);
    check({tag, "_ready"}, ready, p == P_READY);
    check({tag, "_busy"}, busy, p == P_SU || p == P_ST || p == P_SD);
    check({tag, "_fail"}, fail, p == P_FAIL);
    check({tag, "_rc"}, last_rc, m_rc);
  endtask
  task automatic do_start(input logic t, input logic st);
    start = 1'b1; su_type = t; do_st = st;
    tick;
    start = 1'b0; su_type = 1'($urandom); do_st = 1'($urandom);
    check("init_pulse", bus.tpm_init, 1);
    check("init_busy", busy, 1);
    check("init_fail", fail, 0);
    tick;
    check("init_single", bus.tpm_init, 0);
    tick(SETTLE - 1);
    check("settle_quiet", bus.cmd_valid, 0);
    tick;
    check("settle_done", bus.cmd_valid, 1);
  endtask
  task automatic serve(input logic [1:0] e_code, input logic e_param, input logic [4:0] act);
    int w = 0;
    int hold = g_hold >= 0 ? g_hold : $urandom_range(0, 4);
    int dly = g_delay >= 0 ? g_delay : $urandom_range(0, 5);
    while (!bus.cmd_valid && w < 50) begin tick; w++; end
    check("cmd_valid", bus.cmd_valid, 1);
    check("cmd_code", bus.cmd_code, e_code);
    check("cmd_param", bus.cmd_param, e_param);
    repeat (hold) begin
      tick;
      check("hold_valid", bus.cmd_valid, 1);
      check("hold_code", bus.cmd_code, e_code);
      check("hold_param", bus.cmd_param, e_param);
    end
    bus.cmd_ready = 1'b1;
    tick;
    bus.cmd_ready = 1'b0;
    check("wait_valid", bus.cmd_valid, 0);
    if (act[4]) begin
      tick(TMO - 1);
      check("pre_timeout_fail", fail, 0);
      tick;
      check("timeout_valid", bus.cmd_valid, 0);
      m_rc = 4'h0;
    end else begin
      tick(dly);
      bus.rsp_valid = 1'b1; bus.rsp_code = act[3:0];
      tick;
      bus.rsp_valid = 1'b0; bus.rsp_code = 4'($urandom);
      m_rc = act[3:0];
    end
  endtask
  function automatic logic [4:0] pick();
    int r = $urandom_range(0, 15);
    if (plan.size() > 0) return plan.pop_front();
    return r < 9 ? 5'h0F : r < 12 ? 5'h02 : r < 13 ? 5'h00 : r < 14 ? 5'h01 : r < 15 ? 5'h0F : 5'h10;
  endfunction
  task automatic run_seq(input logic t, input logic st);
    int p = P_SU;
    logic [1:0] e_code = 2'd0;
    logic e_param = t;
    bit retried = 0;
    logic [4:0] act;
    bit ok;
    do_start(t, st);
    while (p == P_SU || p == P_ST || p == P_SD) begin
      act = pick();
      serve(e_code, e_param, act);
      g_hold = -1;
      ok = !act[4] && act[3:0] == 4'hF;
      if (p == P_SU) begin
        if (ok && st) begin p = P_ST; e_code = 2'd2; e_param = 1'b0; end
        else if (ok) p = P_READY;
        else if (!act[4] && act[3:0] == 4'h2 && e_param && !retried) begin retried = 1; e_param = 1'b0; end
        else p = P_FAIL;
      end else if (p == P_ST) p = ok ? P_READY : P_FAIL;
      else p = ok ? P_IDLE : P_FAIL;
      check_phase("after_rsp", p);
      if (p == P_READY) begin
        bus.rsp_valid = 1'b1; bus.rsp_code = 4'h0; start = 1'b1;
        tick;
        bus.rsp_valid = 1'b0; start = 1'b0;
        check("ready_no_init", bus.tpm_init, 0);
        check_phase("ready_ignore", p);
        tick($urandom_range(0, 3));
        sd_req = 1'b1; sd_type = 1'($urandom); e_param = sd_type;
        tick;
        sd_req = 1'b0; sd_type = ~sd_type;
        p = P_SD; e_code = 2'd1;
      end
    end
  endtask
  initial begin
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_code = 4'h0;
    #2 rst_n = 1'b0;
    #10 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    tick;
    check_reset_outputs("post_reset");
    g_hold = 10; g_delay = 2;
    plan = '{5'h0F, 5'h0F, 5'h0F};
    run_seq(1'b0, 1'b1);
    plan = '{5'h02, 5'h0F, 5'h0F};
    run_seq(1'b1, 1'b0);
    plan = '{5'h02, 5'h02};
    run_seq(1'b1, 1'b1);
    g_delay = -1;
    plan = '{5'h10};
    run_seq(1'b0, 1'b0);
    g_delay = TMO - 1;
    plan = '{5'h0F, 5'h0F, 5'h0F};
    run_seq(1'b1, 1'b1);
    g_delay = -1;
    repeat (30) run_seq(1'($urandom), 1'($urandom));
    plan = '{5'h0F};
    do_start(1'b0, 1'b1);
    serve(2'd0, 1'b0, pick());
    check("st_presented", bus.cmd_code, 2);
    bus.cmd_ready = 1'b1;
    tick;
    bus.cmd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    m_rc = 4'hF;
    @(negedge clk) rst_n = 1'b1;
    tick;
    check_reset_outputs("mid_reset_rel");
    plan = '{5'h0F, 5'h0F, 5'h0F};
    run_seq(1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
